// File: rtl/seg_scan_mux.sv
// Time-multiplexed seven-segment scanner with frame-aligned double-buffered display word
// and optional leading-zero blanking. Outputs are fully registered.
module seg_scan_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] din,
    input  logic                    load,
    input  logic                    en,
    input  logic                    lzb,
    output logic [3:0]              bcd,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    busy,
    output logic                    frame_done
);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PLAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] ILAST = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]                 presc;
    logic [IW-1:0]                 idx, idx_nxt;
    logic [NUM_DIGITS-1:0][3:0]    disp, pend, disp_nxt, din_w;
    logic [NUM_DIGITS-1:0]         hi_zero;
    logic                          tick, boundary, blank;

    assign din_w    = din;
    assign tick     = (presc == PLAST);
    assign boundary = tick && (idx == ILAST);

    always_comb begin
        idx_nxt = idx;
        if (tick)
            idx_nxt = (idx == ILAST) ? '0 : idx + IW'(1);
    end

    // A load landing on the boundary bypasses pend so the freshest value wins.
    always_comb begin
        disp_nxt = disp;
        if (boundary) begin
            if (load)
                disp_nxt = din_w;
            else if (busy)
                disp_nxt = pend;
        end
    end

    // hi_zero[i]: nibbles i..NUM_DIGITS-1 of the upcoming display word are all zero.
    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_zero
            if (g == NUM_DIGITS - 1) begin : g_top
                assign hi_zero[g] = ~|disp_nxt[g];
            end else begin : g_mid
                assign hi_zero[g] = ~|disp_nxt[g] & hi_zero[g+1];
            end
        end
    endgenerate

    assign blank = lzb && (idx_nxt != '0) && hi_zero[idx_nxt];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc      <= '0;
            idx        <= '0;
            disp       <= '0;
            pend       <= '0;
            busy       <= 1'b0;
            an         <= '1;
            bcd        <= '0;
            frame_done <= 1'b0;
        end else begin
            presc      <= tick ? '0 : presc + PW'(1);
            idx        <= idx_nxt;
            disp       <= disp_nxt;
            frame_done <= boundary;
            if (boundary) begin
                busy <= 1'b0;
            end else if (load) begin
                pend <= din_w;
                busy <= 1'b1;
            end
            bcd <= disp_nxt[idx_nxt];
            an  <= (en && !blank) ? ~(NUM_DIGITS'(1) << idx_nxt) : '1;
        end
    end
endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: cycle-count based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_seg_scan_mux;
    localparam int N = 4;
    localparam int R = 4;
    localparam int W = 4 * N;

    logic          clk, rst_n, load, en, lzb;
    logic [W-1:0]  din;
    logic [3:0]    bcd;
    logic [N-1:0]  an;
    logic          busy, frame_done;

    int vectors = 0;
    int miscompares = 0;
    bit chk_on = 0;

    seg_scan_mux #(.NUM_DIGITS(N), .REFRESH_DIV(R)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .load(load), .en(en), .lzb(lzb),
        .bcd(bcd), .an(an), .busy(busy), .frame_done(frame_done)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Model state: time is a plain cycle count since reset release.
    int           m_cnt;
    logic [W-1:0] m_disp, m_pend, m_nd;
    logic         m_busy, e_fd;
    logic [3:0]   e_bcd;
    logic [N-1:0] e_an;

    function automatic int slot(input int c);
        return (c / R) % N;
    endfunction

    function automatic bit is_bnd(input int c);
        return (c % R == R - 1) && (slot(c) == N - 1);
    endfunction

    function automatic logic [3:0] nib(input logic [W-1:0] d, input int i);
        logic [W-1:0] t;
        t = d >> (4 * i);
        return t[3:0];
    endfunction

    function automatic logic [N-1:0] exp_an(input logic [W-1:0] d, input int i,
                                            input logic e, input logic z);
        logic [N-1:0] one;
        one = 1;
        if (!e) return '1;
        if (z && i > 0 && (d >> (4 * i)) == 0) return '1;
        return ~(one << i);
    endfunction

    always_comb begin
        m_nd = m_disp;
        if (is_bnd(m_cnt)) begin
            if (load) m_nd = din;
            else if (m_busy) m_nd = m_pend;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0; m_disp <= '0; m_pend <= '0; m_busy <= 0;
            e_an <= '1; e_bcd <= '0; e_fd <= 0;
        end else begin
            m_cnt  <= m_cnt + 1;
            m_disp <= m_nd;
            if (is_bnd(m_cnt)) m_busy <= 0;
            else if (load) begin m_pend <= din; m_busy <= 1; end
            e_fd  <= is_bnd(m_cnt);
            e_bcd <= nib(m_nd, slot(m_cnt + 1));
            e_an  <= exp_an(m_nd, slot(m_cnt + 1), en, lzb);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_bcd", 32'(bcd), 32'(e_bcd));
            check("model_an", 32'(an), 32'(e_an));
            check("model_busy", 32'(busy), 32'(m_busy));
            check("model_fd", 32'(frame_done), 32'(e_fd));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 0; load = 0; din = '0; en = 1; lzb = 0;
        step(2);
        check("rst_an", 32'(an), 32'hF);
        check("rst_bcd", 32'(bcd), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_fd", 32'(frame_done), 32'h0);
        chk_on = 1;

        // Scenario 1: load 1234 in the first cycle after release.
        rst_n = 1; load = 1; din = 16'h1234;
        step(1); load = 0;
        check("s1_busy_load", 32'(busy), 32'h1);
        check("s1_an_first", 32'(an), 32'hE);
        check("s1_bcd_first", 32'(bcd), 32'h0);
        step(14);
        check("s1_busy_pre", 32'(busy), 32'h1);
        check("s1_an_slot3", 32'(an), 32'h7);
        step(1);
        check("s1_fd", 32'(frame_done), 32'h1);
        check("s1_busy_post", 32'(busy), 32'h0);
        check("s1_bcd_d0", 32'(bcd), 32'h4);
        check("s1_an_d0", 32'(an), 32'hE);
        for (int k = 1; k < 4; k++) begin
            step(4);
            check("s1_bcd_seq", 32'(bcd), 32'(4 - k));
            check("s1_an_seq", 32'(an), 32'(4'hF & ~(4'h1 << k)));
        end
        step(4);
        check("s1_fd2", 32'(frame_done), 32'h1);

        // Scenario 2: two loads in one frame, last wins.
        load = 1; din = 16'hABCD; step(1); load = 0; step(1);
        load = 1; din = 16'h0F00; step(1); load = 0;
        step(13);
        check("s2_d0", 32'(bcd), 32'h0);
        step(4); check("s2_d1", 32'(bcd), 32'h0);
        step(4); check("s2_d2", 32'(bcd), 32'hF);
        step(4); check("s2_d3", 32'(bcd), 32'h0);

        // Scenario 3: load exactly in the boundary cycle.
        step(3); load = 1; din = 16'h5555; step(1); load = 0;
        check("s3_bcd", 32'(bcd), 32'h5);
        check("s3_busy", 32'(busy), 32'h0);

        // Scenario 4: leading-zero blanking.
        lzb = 1; load = 1; din = 16'h0040; step(1); load = 0;
        step(15);
        check("s4_an0", 32'(an), 32'hE); check("s4_bcd0", 32'(bcd), 32'h0);
        step(4);
        check("s4_an1", 32'(an), 32'hD); check("s4_bcd1", 32'(bcd), 32'h4);
        step(4); check("s4_an2", 32'(an), 32'hF);
        step(4); check("s4_an3", 32'(an), 32'hF);
        load = 1; din = 16'h0000; step(1); load = 0; step(3);
        check("s4_zero_d0", 32'(an), 32'hE);
        step(4); check("s4_zero_d1", 32'(an), 32'hF);

        // Scenario 5: en dropped mid-slot, phase keeps running.
        lzb = 0; step(1); en = 0; step(1);
        check("s5_off", 32'(an), 32'hF);
        step(5); en = 1; step(1);
        check("s5_resume", 32'(an), 32'h7);

        // Random phase against the model.
        for (int i = 0; i < 400; i++) begin
            load = ($urandom_range(0, 9) == 0);
            din  = W'($urandom);
            if ($urandom_range(0, 3) == 0) din = W'($urandom_range(0, 255));
            en   = ($urandom_range(0, 7) != 0);
            if (i % 50 == 0) lzb = $urandom_range(0, 1) == 1;
            step(1);
        end
        load = 0; en = 1; lzb = 0;

        // Scenario 6: asynchronous reset with a pending value.
        load = 1; din = 16'h9876; step(1); load = 0; step(2);
        check("s6_busy_pre", 32'(busy), 32'h1);
        #2 rst_n = 0;
        #1;
        check("s6_rst_an", 32'(an), 32'hF);
        check("s6_rst_bcd", 32'(bcd), 32'h0);
        check("s6_rst_busy", 32'(busy), 32'h0);
        step(2); rst_n = 1;
        step(1);
        check("s6_an", 32'(an), 32'hE);
        check("s6_bcd", 32'(bcd), 32'h0);
        step(15);
        check("s6_bcd_frame", 32'(bcd), 32'h0);
        check("s6_busy_frame", 32'(busy), 32'h0);
        step(20);

        chk_on = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Time-multiplexed scanner for the ALU result on a common-anode multi-digit seven-segment display.
- Holds a NUM_DIGITS×4-bit display word and steps through it one nibble at a time.
- Each step drives the current nibble on bcd, to the BCD-to-seven-segment decoder, and asserts the matching active-low digit anode.
- Updates to the display word are double-buffered and applied only at frame boundaries, so the display never tears.

Parameters:
- NUM_DIGITS, 4: number of digits scanned (2..8).
- REFRESH_DIV, 50000: clk cycles per digit slot; must be ≥2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- din  in  4*NUM_DIGITS  value to display; nibble i goes to digit i, digit 0 is rightmost.
- load  in  1  one-cycle strobe; captures din.
- en  in  1  1 = display on; 0 = all anodes off.
- lzb  in  1  1 = blank leading zeros.
- bcd  out  4  current nibble, to the decoder input (decoder upper input bits tied 0).
- an  out  NUM_DIGITS  digit anodes, active-low, one-hot-low when lit.
- busy  out  1  a captured value is pending and not yet displayed.
- frame_done  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Clock, reset and register rules
  - Single clock domain.
  - rst_n low asynchronously clears all state: prescaler=0, idx=0, disp=0, pend=0, busy=0, an=all 1s, bcd=0, frame_done=0.
  - Reset mid-frame or with a pending load discards everything. The first slot after release is digit 0 with disp=0.
  - All outputs are registered; there is no combinational path from any input to any output.
- Prescaler and tick
  - Prescaler counts 0..REFRESH_DIV-1 and wraps to 0.
  - tick = (prescaler==REFRESH_DIV-1).
- Digit index
  - idx advances on tick: 0→1→…→NUM_DIGITS-1→0.
  - boundary = tick && idx==NUM_DIGITS-1.
- Double buffer
  - load=1 and not boundary: pend<=din, busy<=1. A second load while busy overwrites pend (last wins).
  - boundary and load=1: disp<=din, busy<=0; the current din bypasses pend.
  - boundary and busy and no load: disp<=pend, busy<=0.
  - boundary and neither: disp is unchanged.
- frame_done
  - Registered: high for exactly the cycle after each boundary edge.
- Output update timing
  - an and bcd are computed from next-state idx and next-state disp, so they change on the same edge as idx.
  - The new disp is visible on digit 0 in the same cycle the index wraps.
- Digit output encoding
  - bcd = disp nibble[idx_next].
  - an = ~(1<<idx_next) when lit.
  - an = all 1s when en==0 (en sampled at the edge, one cycle latency) or when the digit is blanked.
  - bcd still carries the nibble when an is off.
- Leading-zero blanking
  - Applies when lzb=1.
  - Digit i>0 is blanked iff every nibble of disp from i to NUM_DIGITS-1 is 0.
  - Digit 0 is never blanked, so 0 displays as a single "0".
- Nibble values
  - Nibbles are passed through unmodified, A–F included; the decoder renders hex.
- Prescaler and idx continue running while en==0.

Test Plan:
All scenarios use NUM_DIGITS=4 and REFRESH_DIV=4.
1. Reset, then load din=16'h1234 in the first cycle, en=1, lzb=0.
   - bcd sequence is 4,3,2,1.
   - an sequence is 1110,1101,1011,0111, each held 4 cycles.
   - The value appears only after the first boundary.
   - busy is high from the load until that boundary.
   - frame_done pulses once per 16 cycles.
2. Load din=16'hABCD, then load din=16'h0F00 two cycles later, in the same frame.
   - After the boundary the display shows 0,0,F,0; ABCD is never shown.
3. Load din=16'h5555 exactly in the boundary cycle.
   - The next slot shows digit 0 = 5 and busy stays 0.
4. lzb=1 with disp=16'h0040.
   - Digits 3 and 2 have an=1111; digit 1 is lit with bcd=4; digit 0 is lit with bcd=0.
   - With disp=16'h0000, only digit 0 lights.
5. Drop en to 0 mid-slot.
   - an goes to 1111 one cycle later; idx continues.
   - Re-raising en resumes at the current idx with no phase loss.
6. Assert rst_n low mid-frame with busy=1.
   - an=1111, bcd=0 and busy=0 immediately, without waiting for a clock edge.
   - After release, digit 0 shows 0 and the pending value is gone.
